// File: rtl/arb2to1.sv
// Two-requester burst arbiter: one-cycle grant latency, round-robin priority, bursts capped at MAX_BURST.
// Backpressure: out_ready low freezes grant, select and beat count; out is a combinational mux of w0/w1.
module arb2to1 #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] w0,
  input  logic [DATA_W-1:0] w1,
  input  logic              out_ready,
  output logic              gnt0,
  output logic              gnt1,
  output logic              s,
  output logic [DATA_W-1:0] out,
  output logic              out_valid
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             prio;
  logic             prio_nxt;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] beat_cnt_nxt;

  logic own_req;
  logic other_req;
  logic xfer;
  logic grant_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      prio     <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      prio     <= prio_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Owner's request qualifies the beat; in IDLE nobody owns the channel.
  always_comb begin
    own_req   = 1'b0;
    other_req = 1'b0;
    case (state)
      G0: begin
        own_req   = req0;
        other_req = req1;
      end
      G1: begin
        own_req   = req1;
        other_req = req0;
      end
      default: begin
        own_req   = 1'b0;
        other_req = 1'b0;
      end
    endcase
  end

  assign xfer      = own_req & out_ready;
  assign grant_end = (state != IDLE) && (!own_req || (xfer && (beat_cnt == LAST_BEAT)));

  always_comb begin
    state_nxt    = state;
    prio_nxt     = prio;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        beat_cnt_nxt = '0;
        if (req0 && req1)
          state_nxt = prio ? G1 : G0;
        else if (req0)
          state_nxt = G0;
        else if (req1)
          state_nxt = G1;
      end
      G0, G1: begin
        if (grant_end) begin
          // Hand priority to the other side; switch directly if it is waiting.
          prio_nxt     = (state == G0);
          beat_cnt_nxt = '0;
          if (other_req)
            state_nxt = (state == G0) ? G1 : G0;
          else if (!own_req)
            state_nxt = IDLE;
        end else if (xfer) begin
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt    = IDLE;
        beat_cnt_nxt = '0;
      end
    endcase
  end

  assign gnt0      = (state == G0);
  assign gnt1      = (state == G1);
  assign s         = (state == G1);
  assign out_valid = own_req;
  assign out       = s ? w1 : w0;

endmodule

// File: tb/tb_arb2to1.sv
// Bench for arb2to1: three instances (MAX_BURST 4, 2, 1) on shared inputs against an owner/beat model.
module tb_arb2to1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] w0 = 8'h00;
  logic [7:0] w1 = 8'h00;

  logic       gnt0_o [3];
  logic       gnt1_o [3];
  logic       s_o    [3];
  logic       vld_o  [3];
  logic [7:0] out_o  [3];
  logic [7:0] cnt_o  [3];
  logic       prio_o [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int owner;
    int beats;
    bit prio;
  } mdl_t;

  mdl_t m [3];
  int   maxb [3] = '{4, 2, 1};

  always #5 clk = ~clk;

  arb2to1 #(.DATA_W(8), .MAX_BURST(4)) u4 (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .w0(w0), .w1(w1),
    .out_ready(out_ready), .gnt0(gnt0_o[0]), .gnt1(gnt1_o[0]), .s(s_o[0]),
    .out(out_o[0]), .out_valid(vld_o[0]));

  arb2to1 #(.DATA_W(8), .MAX_BURST(2)) u2 (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .w0(w0), .w1(w1),
    .out_ready(out_ready), .gnt0(gnt0_o[1]), .gnt1(gnt1_o[1]), .s(s_o[1]),
    .out(out_o[1]), .out_valid(vld_o[1]));

  arb2to1 #(.DATA_W(8), .MAX_BURST(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .w0(w0), .w1(w1),
    .out_ready(out_ready), .gnt0(gnt0_o[2]), .gnt1(gnt1_o[2]), .s(s_o[2]),
    .out(out_o[2]), .out_valid(vld_o[2]));

  always_comb begin
    cnt_o[0]  = 8'(u4.beat_cnt);
    cnt_o[1]  = 8'(u2.beat_cnt);
    cnt_o[2]  = 8'(u1.beat_cnt);
    prio_o[0] = u4.prio;
    prio_o[1] = u2.prio;
    prio_o[2] = u1.prio;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      m[d].owner = -1;
      m[d].beats = 0;
      m[d].prio  = 1'b0;
    end
  endfunction

  // Advance the model by one rising edge using the inputs present before the edge.
  function automatic void model_step(int d, bit r0, bit r1, bit rdy);
    bit rq [2];
    bit own;
    bit oth;
    bit done;
    rq[0] = r0;
    rq[1] = r1;
    if (m[d].owner < 0) begin
      if (r0 && r1) m[d].owner = m[d].prio ? 1 : 0;
      else if (r0)  m[d].owner = 0;
      else if (r1)  m[d].owner = 1;
      m[d].beats = 0;
    end else begin
      own  = rq[m[d].owner];
      oth  = rq[1 - m[d].owner];
      done = !own;
      if (own && rdy) begin
        m[d].beats++;
        if (m[d].beats == maxb[d]) done = 1'b1;
      end
      if (done) begin
        m[d].prio  = (m[d].owner == 0);
        m[d].beats = 0;
        if (oth)       m[d].owner = 1 - m[d].owner;
        else if (!own) m[d].owner = -1;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    bit       ev;
    bit [7:0] eo;
    for (int d = 0; d < 3; d++) begin
      ev = (m[d].owner == 0 && req0) || (m[d].owner == 1 && req1);
      eo = (m[d].owner == 1) ? w1 : w0;
      chk($sformatf("%s_gnt0_d%0d", tag, d), gnt0_o[d], (m[d].owner == 0));
      chk($sformatf("%s_gnt1_d%0d", tag, d), gnt1_o[d], (m[d].owner == 1));
      chk($sformatf("%s_s_d%0d", tag, d), s_o[d], (m[d].owner == 1));
      chk($sformatf("%s_vld_d%0d", tag, d), vld_o[d], ev);
      chk($sformatf("%s_out_d%0d", tag, d), out_o[d], eo);
      chk($sformatf("%s_cnt_d%0d", tag, d), cnt_o[d], m[d].beats);
      chk($sformatf("%s_prio_d%0d", tag, d), prio_o[d], m[d].prio);
    end
  endtask

  // Entered shortly after a rising edge; leaves 1 time unit after the next one.
  task automatic cycle(input bit r0, input bit r1, input bit rdy,
                       input logic [7:0] d0, input logic [7:0] d1);
    req0      = r0;
    req1      = r1;
    out_ready = rdy;
    w0        = d0;
    w1        = d1;
    #1;
    check_all("pre");
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_step(d, r0, r1, rdy);
    #1;
    check_all("post");
  endtask

  // Asserts reset between edges, checks the immediate effect, then releases between edges.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst");
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    bit r0;
    bit r1;
    bit rdy;
    model_reset();

    // Reset state
    #1;
    check_all("init");
    chk("init_gnt0", gnt0_o[0], 1'b0);
    chk("init_vld", vld_o[0], 1'b0);
    do_reset();

    // Single requester 0, one-cycle grant latency, continuous transfers
    cycle(1, 0, 1, 8'hA5, 8'h3C);
    chk("r33_gnt0", gnt0_o[0], 1'b1);
    chk("r33_s", s_o[0], 1'b0);
    chk("r33_out", out_o[0], 8'hA5);
    chk("r33_vld", vld_o[0], 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 1, 8'hA5, 8'h3C);
      chk("r33_cnt", cnt_o[0], 8'(i + 1));
    end

    // Both requesting, bursts of 4 alternate with no idle bubble
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(1, 1, 1, 8'(i), 8'(8'h80 + i));
      chk("r34_s", s_o[0], (i >= 4 && i < 8));
      chk("r34_busy", gnt0_o[0] | gnt1_o[0], 1'b1);
    end

    // MAX_BURST=1 alternates every transfer
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1, 1, 1, 8'h11, 8'h22);
      chk("r29_s", s_o[2], i % 2);
    end

    // Drop req1 mid-burst: idle, prio back to 0, then req0 wins a tie
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 8'h01, 8'h02);
    chk("r35_gnt1", gnt1_o[0], 1'b1);
    chk("r35_cnt", cnt_o[0], 8'd2);
    cycle(0, 0, 1, 8'h01, 8'h02);
    chk("r35_idle", gnt0_o[0] | gnt1_o[0], 1'b0);
    chk("r35_prio", prio_o[0], 1'b0);
    cycle(1, 1, 1, 8'h01, 8'h02);
    chk("r35_win0", gnt0_o[0], 1'b1);

    // Backpressure holds grant and count
    do_reset();
    cycle(1, 1, 1, 8'h44, 8'h55);
    cycle(1, 1, 1, 8'h44, 8'h55);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 0, 8'h44, 8'h55);
      chk("r36_gnt0", gnt0_o[0], 1'b1);
      chk("r36_s", s_o[0], 1'b0);
      chk("r36_cnt", cnt_o[0], 8'd1);
    end
    cycle(1, 1, 1, 8'h44, 8'h55);
    chk("r36_resume", cnt_o[0], 8'd2);
    cycle(1, 1, 1, 8'h44, 8'h55);
    cycle(1, 1, 1, 8'h44, 8'h55);
    chk("r36_handoff", gnt1_o[0], 1'b1);

    // Asynchronous reset during G1 beat 3
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 8'h66, 8'h77);
    chk("r37_cnt", cnt_o[0], 8'd2);
    req1 = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("r37_gnt1", gnt1_o[0], 1'b0);
    chk("r37_s", s_o[0], 1'b0);
    chk("r37_vld", vld_o[0], 1'b0);
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    #1;
    cycle(0, 1, 1, 8'h66, 8'h77);
    chk("r37_regrant", gnt1_o[0], 1'b1);
    chk("r37_cnt0", cnt_o[0], 8'd0);

    // Lone requester with MAX_BURST=2 keeps the grant without a gap
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 1, 8'h0F, 8'(i));
      chk("r38_gnt1", gnt1_o[1], 1'b1);
      chk("r38_vld", vld_o[1], 1'b1);
    end

    // Random traffic; requests only change while the channel is ready
    do_reset();
    r0 = 1'b0;
    r1 = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      rdy = ($urandom_range(0, 3) != 0);
      if (rdy) begin
        r0 = ($urandom_range(0, 3) != 0);
        r1 = ($urandom_range(0, 3) != 0);
      end
      cycle(r0, r1, rdy, 8'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb2to1.md
ARB2TO1 -- requirements
Module: arb2to1

Interface
REQ-001 Parameter DATA_W, default 8, width of each data input and of the output data.
REQ-002 Parameter MAX_BURST, default 4, maximum transfers per grant; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req0  input  1  requester 0 wants the output channel; held high while it has data.
REQ-006 req1  input  1  requester 1 wants the output channel; held high while it has data.
REQ-007 w0  input  DATA_W  requester 0 data.
REQ-008 w1  input  DATA_W  requester 1 data.
REQ-009 out_ready  input  1  downstream accepts out this cycle.
REQ-010 gnt0  output  1  requester 0 currently owns the channel.
REQ-011 gnt1  output  1  requester 1 currently owns the channel.
REQ-012 s  output  1  mux select: 0 routes w0, 1 routes w1.
REQ-013 out  output  DATA_W  selected data.
REQ-014 out_valid  output  1  out holds a valid beat.

Function
REQ-015 The FSM SHALL have three registered states: IDLE, G0, G1.
REQ-016 gnt0 SHALL be high only in G0, gnt1 only in G1; both never high together.
REQ-017 s SHALL be 1 in G1 and 0 in IDLE and G0, derived from registered state only.
REQ-018 out SHALL equal w1 when s=1, else w0, combinationally.
REQ-019 out_valid SHALL be (G0 & req0) | (G1 & req1); IDLE drives out_valid=0.
REQ-020 A transfer SHALL occur on a rising edge where out_valid & out_ready are both 1.
REQ-021 A registered priority bit prio SHALL select the winner when both requests are high: prio=0 favours req0, prio=1 favours req1.
REQ-022 From IDLE: only req0 -> G0; only req1 -> G1; both -> per prio; neither -> stay IDLE. Grant latency SHALL be exactly one cycle from request.
REQ-023 A beat counter (ceil(log2(MAX_BURST+1)) bits) SHALL clear on entering any grant state and increment on each transfer.
REQ-024 A grant SHALL end at the edge where the owner's req is low, or where the transfer completing beat MAX_BURST occurs.
REQ-025 On grant end, prio SHALL point to the other requester.
REQ-026 On grant end, next state: other requester's req high -> other grant state directly (no IDLE bubble); else own req still high -> re-enter same grant with counter cleared; else IDLE.
REQ-027 When out_ready is low, grant, s, out_valid and counter SHALL hold; no beat is counted.
REQ-028 If req drops and out_ready is high in the same cycle, no transfer occurs (out_valid=0) and the grant ends per REQ-024.
REQ-029 With MAX_BURST=1, grants SHALL alternate every transfer under continuous dual requests.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, prio=0, counter=0, gnt0=gnt1=0, s=0, out_valid=0, regardless of clock.
REQ-031 Reset asserted mid-burst SHALL discard the burst; after release the arbiter restarts from IDLE with prio=0.
REQ-032 The first rising edge after rst_n rises SHALL be treated as a normal IDLE evaluation.

Verification
REQ-033 Reset then req0=1, req1=0, w0=8'hA5, out_ready=1 -> next cycle gnt0=1, s=0, out=8'hA5, out_valid=1; transfers each cycle.
REQ-034 Both req held high, out_ready=1, MAX_BURST=4 -> G0 for 4 transfers, then G1 for 4, then G0; s toggles 0->1->0, no IDLE cycle between.
REQ-035 In G1 after 2 beats drop req1 with req0=0 -> IDLE next cycle, prio=0; then raise both -> G0 wins.
REQ-036 In G0, out_ready=0 for 3 cycles with req1=1 -> gnt0 stays 1, s=0, counter unchanged; burst resumes when out_ready returns.
REQ-037 Assert rst_n=0 between clock edges during G1 beat 3 -> gnt1, s, out_valid fall without a clock edge; after release with req1=1 -> G1 after one cycle with counter 0.
REQ-038 Only req1 high continuously, MAX_BURST=2, out_ready=1 -> G1 re-entered every 2 beats, gnt1 never drops, out_valid continuous.
